// File: rtl/lsu_mem_master.sv
// lsu_mem_master: byte-addressed load/store initiator over a word-wide memory port with sub-word RMW
module lsu_mem_master #(
  parameter int AW = 11,
  parameter int DW = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_func3,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    mem_func3
);
  localparam int CW = $clog2(RD_LAT + 1) + 1;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic          we_q, err_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [DW-1:0] wd_q, rd_q;
  logic [CW-1:0] cnt;
  logic          accept, ill, mis, last, is_sw;
  logic [4:0]    sh;
  logic [DW-1:0] mask, merged, lane, ext;
  logic          unused_addr;
  assign unused_addr = ^{req_addr[31:AW+2]};
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign ill = req_we ? (req_func3 >= 3'd3) : (req_func3 == 3'd3 || req_func3[2:1] == 2'b11);
  assign mis = (req_func3[1:0] == 2'b01 && req_addr[0]) || (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign is_sw = req_we && req_func3 == 3'b010;
  assign last = cnt == CW'(RD_LAT);
  assign sh = {off_q, 3'b000};
  assign mask = (f3_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << sh;
  assign merged = (mem_rdata & ~mask) | ((wd_q << sh) & mask);
  assign lane = rd_q >> sh;
  assign ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
               f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : lane;
  assign resp_valid = state == RESP;
  assign resp_err = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? ext : '0;
  assign mem_wr = state == WRITE && !reset;
  assign mem_func3 = 3'b010;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = !accept ? IDLE : (ill || mis) ? RESP : is_sw ? WRITE : READ;
      READ:  state_nx = !last ? READ : we_q ? WRITE : RESP;
      WRITE: state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      wd_q      <= '0;
      rd_q      <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      we_q     <= req_we;
      err_q    <= ill || mis;
      f3_q     <= req_func3;
      off_q    <= req_addr[1:0];
      wd_q     <= req_wdata;
      cnt      <= '0;
      mem_addr <= req_addr[AW+1:2];
      if (is_sw) mem_wdata <= req_wdata;
    end else if (state == READ) begin
      cnt <= cnt + 1'b1;
      if (last) rd_q <= mem_rdata;
      if (last && we_q) mem_wdata <= merged;
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed checks of loads, RMW stores, errors and reset behaviour
module tb_lsu_mem_master;
  localparam int AW = 11;
  localparam int RD_LAT = 1;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_we = 0;
  logic [2:0] req_func3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_wr;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [2:0] mem_func3;
  logic [31:0] mem [0:(1<<AW)-1];
  logic bd_we = 0;
  logic [AW-1:0] bd_addr = 0;
  logic [31:0] bd_data = 0;
  int checks = 0, failures = 0;

  lsu_mem_master #(.AW(AW), .DW(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_func3(mem_func3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
    mem_rdata <= mem[mem_addr];
  end

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er, output int nwr,
                     output logic [31:0] wseen, output logic [AW-1:0] aseen);
    lat = -1; rd = 0; er = 0; nwr = 0; wseen = 0; aseen = 0;
    req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0; req_we = ~we; req_func3 = 3'd7; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_wr) begin nwr++; wseen = mem_wdata; end
      aseen = mem_addr;
      if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req_valid = 1; req_we = 0; req_func3 = 3'b010; req_addr = 32'h80;
    bd_we = 1; bd_addr = 11'h20; bd_data = 32'h8899_AABB;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({req_ready, mem_wr, resp_valid} !== 3'b100 || mem_addr !== '0 || resp_rdata !== 0 || mem_func3 !== 3'b010) begin
        failures++;
        $display("FAIL reset_outputs: ready/wr/valid=%b addr=%h rdata=%h f3=%b, required 100 0 0 010",
                 {req_ready, mem_wr, resp_valid}, mem_addr, resp_rdata, mem_func3);
      end
    end
    @(posedge clk);
    #1 reset = 0; req_valid = 0; bd_we = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || resp_valid !== 0) begin
      failures++;
      $display("FAIL reset_no_accept: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw;
    int lat, nwr; logic [31:0] rd, ws; logic er; logic [AW-1:0] as;
    run(0, 3'b010, 32'h80, 0, lat, rd, er, nwr, ws, as);
    checks++;
    if (lat !== RD_LAT + 2 || rd !== 32'h8899_AABB || er !== 0 || nwr !== 0 || as !== 11'h20) begin
      failures++;
      $display("FAIL lw: lat=%0d rdata=%h err=%b wr=%0d addr=%h, required %0d 8899aabb 0 0 020",
               lat, rd, er, nwr, as, RD_LAT + 2);
    end
  endtask

  task automatic test_subword_loads;
    logic [2:0] f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad [4] = '{32'h83, 32'h83, 32'h82, 32'h80};
    logic [31:0] ex [4] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB};
    int lat, nwr; logic [31:0] rd, ws; logic er; logic [AW-1:0] as;
    for (int i = 0; i < 4; i++) begin
      run(0, f3[i], ad[i], 0, lat, rd, er, nwr, ws, as);
      checks++;
      if (lat !== RD_LAT + 2 || rd !== ex[i] || er !== 0 || nwr !== 0) begin
        failures++;
        $display("FAIL load_f3_%b_addr_%h: lat=%0d rdata=%h err=%b wr=%0d, required %0d %h 0 0",
                 f3[i], ad[i], lat, rd, er, nwr, RD_LAT + 2, ex[i]);
      end
    end
  endtask

  task automatic test_rmw;
    int lat, nwr; logic [31:0] rd, ws; logic er; logic [AW-1:0] as;
    run(1, 3'b000, 32'h81, 32'h1234_56CC, lat, rd, er, nwr, ws, as);
    checks++;
    if (lat !== RD_LAT + 3 || nwr !== 1 || ws !== 32'h8899_CCBB || rd !== 0 || er !== 0 || mem[11'h20] !== 32'h8899_CCBB) begin
      failures++;
      $display("FAIL sb: lat=%0d wr=%0d wdata=%h rdata=%h err=%b mem=%h, required %0d 1 8899ccbb 0 0 8899ccbb",
               lat, nwr, ws, rd, er, mem[11'h20], RD_LAT + 3);
    end
    run(1, 3'b001, 32'h82, 32'h0000_DEAD, lat, rd, er, nwr, ws, as);
    checks++;
    if (lat !== RD_LAT + 3 || nwr !== 1 || ws !== 32'hDEAD_CCBB || er !== 0 || mem[11'h20] !== 32'hDEAD_CCBB) begin
      failures++;
      $display("FAIL sh: lat=%0d wr=%0d wdata=%h err=%b mem=%h, required %0d 1 deadccbb 0 deadccbb",
               lat, nwr, ws, er, mem[11'h20], RD_LAT + 3);
    end
  endtask

  task automatic test_errors;
    logic        we [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] ad [3] = '{32'h82, 32'h81, 32'h80};
    int lat, nwr; logic [31:0] rd, ws; logic er; logic [AW-1:0] as;
    for (int i = 0; i < 3; i++) begin
      run(we[i], f3[i], ad[i], 32'hFFFF_FFFF, lat, rd, er, nwr, ws, as);
      checks++;
      if (lat !== 1 || er !== 1 || rd !== 0 || nwr !== 0 || mem[11'h20] !== 32'hDEAD_CCBB) begin
        failures++;
        $display("FAIL err_%0d: lat=%0d err=%b rdata=%h wr=%0d mem=%h, required 1 1 0 0 deadccbb",
                 i, lat, er, rd, nwr, mem[11'h20]);
      end
    end
  endtask

  task automatic test_sw;
    int lat, nwr; logic [31:0] rd, ws; logic er; logic [AW-1:0] as;
    run(1, 3'b010, 32'h84, 32'hCAFE_F00D, lat, rd, er, nwr, ws, as);
    checks++;
    if (lat !== 2 || nwr !== 1 || ws !== 32'hCAFE_F00D || er !== 0 || mem[11'h21] !== 32'hCAFE_F00D || mem[11'h20] !== 32'hDEAD_CCBB) begin
      failures++;
      $display("FAIL sw: lat=%0d wr=%0d wdata=%h err=%b mem21=%h mem20=%h, required 2 1 cafef00d 0 cafef00d deadccbb",
               lat, nwr, ws, er, mem[11'h21], mem[11'h20]);
    end
    run(0, 3'b010, 32'h84, 0, lat, rd, er, nwr, ws, as);
    checks++;
    if (lat !== RD_LAT + 2 || rd !== 32'hCAFE_F00D || nwr !== 0) begin
      failures++;
      $display("FAIL sw_readback: lat=%0d rdata=%h wr=%0d, required %0d cafef00d 0", lat, rd, nwr, RD_LAT + 2);
    end
  endtask

  task automatic test_reset_in_write;
    int seen = 0;
    req_we = 1; req_func3 = 3'b000; req_addr = 32'h80; req_wdata = 32'h77; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (RD_LAT + 1) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    checks++;
    if (mem_wr !== 0) begin
      failures++;
      $display("FAIL rst_write_suppress: mem_wr=%b, required 0", mem_wr);
    end
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || resp_valid !== 0) begin
      failures++;
      $display("FAIL rst_write_idle: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
    end
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_wr) seen++;
    end
    checks++;
    if (seen !== 0 || mem[11'h20] !== 32'hDEAD_CCBB) begin
      failures++;
      $display("FAIL rst_write_quiet: stray=%0d mem=%h, required 0 deadccbb", seen, mem[11'h20]);
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_subword_loads;
    test_rmw;
    test_errors;
    test_sw;
    test_reset_in_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-wide data memory port from the MEM stage.
- Accepts one byte-addressed load/store request from the pipeline at a time.
- Performs all sub-word handling: lane extraction, sign/zero extension, and read-modify-write for SB/SH.
- Always issues full-word (func3=010) accesses to memory. Flags misaligned or illegal requests without touching memory.

Parameters:
- AW, 11, word-address width of the memory port.
- DW, 32, data width; fixed at 32.
- RD_LAT, 1, memory read latency in cycles (0 = combinational read, 1 = registered SRAM read).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at clk edge
- req_we  in  1  1 = store, 0 = load
- req_func3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid
- mem_addr  out  AW  word address, memory_if addr
- mem_wr  out  1  write strobe, memory_if wr
- mem_wdata  out  32  full-word write data, memory_if wdata
- mem_rdata  in  32  full-word read data, memory_if rdata
- mem_func3  out  3  tied to 3'b010

Behaviour:
- Reset is synchronous and dominant. Outputs after reset:
  - state IDLE, req_ready=1
  - resp_valid=0, resp_rdata=0, resp_err=0
  - mem_addr=0, mem_wdata=0, mem_wr=0
- Accept: only in IDLE. Latch we, func3, addr, wdata.
  - word address = req_addr[AW+1:2]; off = req_addr[1:0]
  - Upper address bits are ignored (no range error).
- Error check at accept:
  - loads: func3 in {011,110,111} is illegal
  - stores: func3 >= 011 is illegal
  - halfword with off[0]=1 is misaligned; word with off!=0 is misaligned
  - On error go to RESP with err=1 and no memory access (mem_wr stays 0).
- States and transitions:
  - IDLE -> READ (load, SB, SH) | WRITE (SW) | RESP (error).
  - READ: holds mem_addr with mem_wr=0 for RD_LAT+1 cycles, counted by an internal counter.
  - READ, last cycle: capture mem_rdata. Load -> RESP; SB/SH -> WRITE.
  - WRITE: mem_wr=1 for exactly one cycle, then -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE.
- Load extraction: lane = captured word >> (off*8).
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW passes the word through.
- Store merge: captured word with the addressed lanes replaced.
  - SB: byte lane off = req_wdata[7:0].
  - SH: lanes off, off+1 = req_wdata[15:0].
  - SW: mem_wdata = req_wdata, no read.
- Latency from accept edge (cycle 0) to the resp_valid cycle:
  - load: RD_LAT+2
  - SB/SH: RD_LAT+3
  - SW: 2
  - error: 1
- No response backpressure. The pipeline stalls on !req_ready.
- Next accept is possible in the IDLE cycle after RESP.
- mem_wr = (state==WRITE) && !reset. A reset asserted in the WRITE cycle suppresses the write.
- Reset in any state returns to IDLE next edge with no response emitted.
- mem_addr/mem_wdata are registered and hold the last values in IDLE.
- mem_wr is never asserted outside WRITE.
- req_* inputs are sampled only at accept; changes while busy are ignored.

Test Plan:
- Reset: hold reset for 3 cycles with req_valid=1 -> req_ready=1; mem_wr, resp_valid, mem_addr, resp_rdata all 0; no accept.
- LW, RD_LAT=1: mem[0x20]=0x8899AABB, addr 0x80 -> mem_addr=0x20, mem_wr=0 throughout; resp_valid in cycle 3 with rdata 0x8899AABB, err=0.
- LB/LBU/LH/LHU from the same word:
  - LB addr 0x83 -> 0xFFFFFF88
  - LBU 0x83 -> 0x00000088
  - LH 0x82 -> 0xFFFF8899
  - LHU 0x80 -> 0x0000AABB
- SB/SH read-modify-write: SB addr 0x81, wdata 0x123456CC -> one READ, then a single mem_wr cycle with mem_wdata 0x8899CCBB; resp_valid in cycle 4. Then SH addr 0x82, wdata 0x0000DEAD -> word becomes 0xDEADCCBB.
- Errors: LW addr 0x82, SH addr 0x81, and load func3 011 -> resp_err=1 in cycle 1, rdata=0, mem_wr never asserted, memory unchanged.
- Reset during WRITE: assert reset in the SB WRITE cycle -> mem_wr=0 that cycle, word unchanged; IDLE with req_ready=1 next cycle; no resp_valid.
